window_ctrl: RTL and testbench

WINDOW_CTRL -- requirements
Module: window_ctrl

---
 rtl/window_ctrl.sv | 126 ++++++++++++
 tb/tb_window_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : window_ctrl
//  Brief    : 3x3 sliding-window controller; tracks pixel position and flags
//             complete windows at the registered line-buffer output.
//  Revision : 1.0 - initial release
// ============================================================================
module window_ctrl #(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  localparam int COL_W = ($clog2(IMAGE_WIDTH)  < 1) ? 1 : $clog2(IMAGE_WIDTH),
  localparam int ROW_W = ($clog2(IMAGE_HEIGHT) < 1) ? 1 : $clog2(IMAGE_HEIGHT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             lb_shift_en,
  output logic [COL_W-1:0] col_cnt,
  output logic [ROW_W-1:0] row_cnt,
  output logic             win_valid,
  output logic             frame_done,
  output logic             busy,
  output logic             drop_err
);

  localparam logic [COL_W-1:0] c_col_last = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] c_row_last = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [COL_W-1:0] c_col_two  = COL_W'(2);
  localparam logic [ROW_W-1:0] c_row_one  = ROW_W'(1);
  localparam logic [ROW_W-1:0] c_row_two  = ROW_W'(2);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    ACTIVE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [COL_W-1:0] r_col;
  logic [ROW_W-1:0] r_row;
  logic             r_win_valid;
  logic             r_frame_done;
  logic             r_drop_err;
  logic             w_accept;
  logic             w_row_end;
  logic             w_last_pixel;
  logic             w_ready;
  logic             w_busy;

  assign w_accept     = valid_in & w_ready;
  assign w_row_end    = (r_col == c_col_last);
  assign w_last_pixel = w_accept & w_row_end & (r_row == c_row_last);

  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_busy       = 1'b1;
    case (r_state)
      IDLE: begin
        w_busy = 1'b0;
        if (start) w_next_state = PRIME;
      end
      PRIME: begin
        w_ready = 1'b1;
        if (w_accept && w_row_end && (r_row == c_row_one)) w_next_state = ACTIVE;
      end
      ACTIVE: begin
        w_ready = 1'b1;
        if (w_last_pixel) w_next_state = DONE;
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // Position always names the next pixel to be accepted; row wraps at frame end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
    end else if ((r_state == IDLE) && start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (w_row_end) begin
        r_col <= '0;
        r_row <= (r_row == c_row_last) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // One-cycle delay lines up with the registered line-buffer output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_valid  <= 1'b0;
      r_frame_done <= 1'b0;
      r_drop_err   <= 1'b0;
    end else begin
      r_win_valid  <= w_accept && (r_row >= c_row_two) && (r_col >= c_col_two);
      r_frame_done <= (r_state == ACTIVE) && w_last_pixel;
      if (valid_in && ((r_state == IDLE) || (r_state == DONE))) r_drop_err <= 1'b1;
    end
  end

  assign ready_out   = w_ready;
  assign lb_shift_en = w_accept;
  assign busy        = w_busy;
  assign col_cnt     = r_col;
  assign row_cnt     = r_row;
  assign win_valid   = r_win_valid;
  assign frame_done  = r_frame_done;
  assign drop_err    = r_drop_err;

endmodule
`default_nettype wire

// File: tb/tb_window_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_window_ctrl
//  Brief    : Directed self-checking bench for window_ctrl (4x4 and 5x3).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_window_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_a = 1'b0, valid_a = 1'b0;
  logic       ready_a, shift_a, win_a, done_a, busy_a, drop_a;
  logic [1:0] col_a, row_a;
  logic       start_b = 1'b0, valid_b = 1'b0;
  logic       ready_b, shift_b, win_b, done_b, busy_b, drop_b;
  logic [2:0] col_b;
  logic [1:0] row_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  window_ctrl #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .valid_in(valid_a),
    .ready_out(ready_a), .lb_shift_en(shift_a), .col_cnt(col_a), .row_cnt(row_a),
    .win_valid(win_a), .frame_done(done_a), .busy(busy_a), .drop_err(drop_a)
  );

  window_ctrl #(.IMAGE_WIDTH(5), .IMAGE_HEIGHT(3)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .valid_in(valid_b),
    .ready_out(ready_b), .lb_shift_en(shift_b), .col_cnt(col_b), .row_cnt(row_b),
    .win_valid(win_b), .frame_done(done_b), .busy(busy_b), .drop_err(drop_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame_a();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    chk("start_busy", 32'(busy_a), 1);
    chk("start_ready", 32'(ready_a), 1);
    chk("start_col", 32'(col_a), 0);
    chk("start_row", 32'(row_a), 0);
  endtask

  // Window pulses expected after pixels 11, 12, 15, 16 of a 4x4 frame.
  task automatic frame_a(input int n_pix, input bit gaps, input int start_after, input bit done_start);
    logic [15:0] mask;
    int          pulses;
    int          nk;
    mask   = 16'hCC00;
    pulses = 0;
    for (int k = 1; k <= n_pix; k++) begin
      if (gaps) begin
        valid_a = 1'b0;
        tick();
        chk("gap_win", 32'(win_a), 0);
        chk("gap_done", 32'(done_a), 0);
        chk("gap_col", 32'(col_a), 32'((k - 1) % 4));
        chk("gap_row", 32'(row_a), 32'((k - 1) / 4));
      end
      valid_a = 1'b1;
      #1;
      chk("shift_en", 32'(shift_a), 1);
      tick();
      nk = k % 16;
      chk("win", 32'(win_a), 32'(mask[k-1]));
      chk("done", 32'(done_a), 32'(k == 16));
      chk("col", 32'(col_a), 32'(nk % 4));
      chk("row", 32'(row_a), 32'(nk / 4));
      if (win_a === 1'b1) pulses++;
      if (k == start_after) begin
        valid_a = 1'b0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        chk("restart_col", 32'(col_a), 2);
        chk("restart_row", 32'(row_a), 1);
        chk("restart_busy", 32'(busy_a), 1);
      end
    end
    valid_a = 1'b0;
    if (n_pix == 16) begin
      chk("pulses", 32'(pulses), 4);
      chk("done_ready", 32'(ready_a), 0);
      chk("done_busy", 32'(busy_a), 1);
      start_a = done_start;
      tick();
      start_a = 1'b0;
      chk("idle_busy", 32'(busy_a), 0);
      chk("idle_fd", 32'(done_a), 0);
      chk("idle_win", 32'(win_a), 0);
    end
  endtask

  initial begin
    int pulses_b;

    // Reset state
    tick();
    tick();
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_ready", 32'(ready_a), 0);
    chk("rst_col", 32'(col_a), 0);
    chk("rst_row", 32'(row_a), 0);
    chk("rst_win", 32'(win_a), 0);
    chk("rst_fd", 32'(done_a), 0);
    chk("rst_drop", 32'(drop_a), 0);
    rst = 1'b0;
    tick();
    chk("idle_hold_busy", 32'(busy_a), 0);

    // Continuous frame, then gapped frame started back-to-back; start in DONE ignored
    start_frame_a();
    frame_a(16, 1'b0, 0, 1'b0);
    chk("no_drop", 32'(drop_a), 0);
    start_frame_a();
    frame_a(16, 1'b1, 0, 1'b1);
    chk("no_drop2", 32'(drop_a), 0);

    // Valid while idle sets sticky drop_err
    valid_a = 1'b1;
    #1;
    chk("idle_shift", 32'(shift_a), 0);
    repeat (3) tick();
    valid_a = 1'b0;
    chk("drop_set", 32'(drop_a), 1);
    chk("drop_col", 32'(col_a), 0);
    chk("drop_row", 32'(row_a), 0);
    chk("drop_ready", 32'(ready_a), 0);
    start_frame_a();
    frame_a(16, 1'b0, 0, 1'b0);
    chk("drop_sticky", 32'(drop_a), 1);

    // Start mid-frame ignored
    start_frame_a();
    frame_a(16, 1'b0, 6, 1'b0);

    // Reset mid-frame
    start_frame_a();
    frame_a(9, 1'b0, 0, 1'b0);
    chk("pre_rst_col", 32'(col_a), 1);
    chk("pre_rst_row", 32'(row_a), 2);
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy_a), 0);
    chk("arst_ready", 32'(ready_a), 0);
    chk("arst_col", 32'(col_a), 0);
    chk("arst_row", 32'(row_a), 0);
    chk("arst_drop", 32'(drop_a), 0);
    chk("arst_win", 32'(win_a), 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_busy", 32'(busy_a), 0);
      chk("post_rst_fd", 32'(done_a), 0);
    end
    start_frame_a();
    frame_a(16, 1'b0, 0, 1'b0);

    // 5x3 frame: pulses only on row 2, cols 2-4
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("b_busy", 32'(busy_b), 1);
    pulses_b = 0;
    for (int k = 1; k <= 15; k++) begin
      valid_b = 1'b1;
      tick();
      chk("b_win", 32'(win_b), 32'(k >= 13));
      chk("b_done", 32'(done_b), 32'(k == 15));
      chk("b_col", 32'(col_b), 32'(k % 5));
      chk("b_row", 32'(row_b), 32'((k / 5) % 3));
      if (win_b === 1'b1) pulses_b++;
    end
    valid_b = 1'b0;
    chk("b_pulses", 32'(pulses_b), 3);
    tick();
    chk("b_idle", 32'(busy_b), 0);
    chk("b_drop", 32'(drop_b), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
